// File: rtl/half_adder_1b.sv
// half_adder_1b: single-bit half adder with combinational sum/carry, a
// PIPE_STAGES-deep registered copy of the result with a valid flag, and
// optional saturating statistics counters.
// Optional feature macro: HALF_ADDER_1B_STATS_EN (builds sample_cnt/carry_cnt
// and stats_clr; when undefined the counters read 0 and stats_clr is ignored).
module half_adder_1b #(
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             out_valid,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  typedef struct packed {
    logic valid;
    logic sum;
    logic carry;
  } stage_t;

  // Reject illegal configurations at elaboration.
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
    $error("half_adder_1b: PIPE_STAGES must be in 1..4");
  end
  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $error("half_adder_1b: CNT_W must be in 4..32");
  end

  // Combinational result, independent of clock and reset.
  assign sum   = a ^ b;
  assign carry = a & b;

  stage_t stage_in;
  assign stage_in = '{valid: in_valid, sum: sum, carry: carry};

  // Shift pipeline; data loads every cycle, valid travels alongside.
  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    stage_t q;

    if (g == 0) begin : g_first
      // First stage captures the live combinational result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= stage_in;
      end
    end else begin : g_rest
      // Later stages copy the previous stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= g_stage[g-1].q;
      end
    end

    if (g == PIPE_STAGES - 1) begin : g_last
      assign out_valid = q.valid;
      assign sum_q     = q.sum;
      assign carry_q   = q.carry;
    end
  end

`ifdef HALF_ADDER_1B_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] carry_cnt_q;

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      carry_cnt_q  <= '0;
    end else if (stats_clr) begin
      sample_cnt_q <= '0;
      carry_cnt_q  <= '0;
    end else if (in_valid) begin
      if (sample_cnt_q != CNT_MAX) sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (carry && (carry_cnt_q != CNT_MAX)) carry_cnt_q <= carry_cnt_q + CNT_W'(1);
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign carry_cnt  = carry_cnt_q;
`else
  // Counters not built: outputs tied off, clear input intentionally unused.
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign sample_cnt       = '0;
  assign carry_cnt        = '0;
`endif

endmodule

// File: tb/tb_half_adder_1b.sv
// Testbench for half_adder_1b: truth-table vectors, scoreboarded registered
// path for PIPE_STAGES = 1 and 3, reset mid-stream, latency and counters.
module tb_half_adder_1b;

`ifdef HALF_ADDER_1B_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, rst_n, a, b, in_valid, stats_clr;
  logic sum1, carry1, sq1, cq1, ov1;
  logic sum3, carry3, sq3, cq3, ov3;
  logic [15:0] sc1, cc1;
  logic [3:0]  sc3, cc3;

  half_adder_1b #(.PIPE_STAGES(1), .CNT_W(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum1), .carry(carry1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1),
    .stats_clr(stats_clr), .sample_cnt(sc1), .carry_cnt(cc1)
  );

  half_adder_1b #(.PIPE_STAGES(3), .CNT_W(4)) u_p3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum3), .carry(carry3), .sum_q(sq3), .carry_q(cq3), .out_valid(ov3),
    .stats_clr(stats_clr), .sample_cnt(sc3), .carry_cnt(cc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic sum;
    logic carry;
  } vec_t;

  typedef struct packed {
    logic v;
    logic s;
    logic c;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic [15:0] m1_s, m1_c;
  logic [3:0]  m3_s, m3_c;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] inc_sat(input logic [15:0] v, input logic [15:0] max);
    return (v == max) ? v : v + 16'd1;
  endfunction

  // Compare both registered paths and counters against the scoreboard/model.
  task automatic check_out();
    exp_t e;
    if (q1.size() == 1) e = q1.pop_front(); else e = '0;
    chk("p1_pipe", 32'({ov1, sq1, cq1}), 32'(e));
    if (q3.size() == 3) e = q3.pop_front(); else e = '0;
    chk("p3_pipe", 32'({ov3, sq3, cq3}), 32'(e));
    chk("p1_sample_cnt", 32'(sc1), 32'(m1_s));
    chk("p1_carry_cnt",  32'(cc1), 32'(m1_c));
    chk("p3_sample_cnt", 32'(sc3), 32'(m3_s));
    chk("p3_carry_cnt",  32'(cc3), 32'(m3_c));
  endtask

  // One clock: drive, check combinational result, record expectation, clock, check.
  task automatic step(input logic va, input logic aa, input logic bb, input logic clr);
    exp_t e;
    a = aa; b = bb; in_valid = va; stats_clr = clr;
    #1;
    chk("sum_comb",   32'(sum1),   32'(aa ^ bb));
    chk("carry_comb", 32'(carry3), 32'(aa & bb));
    if (rst_n) begin
      e = '{v: va, s: aa ^ bb, c: aa & bb};
      q1.push_back(e);
      q3.push_back(e);
      if (STATS) begin
        if (clr) begin
          m1_s = '0; m1_c = '0; m3_s = '0; m3_c = '0;
        end else if (va) begin
          m1_s = inc_sat(m1_s, 16'hFFFF);
          m3_s = 4'(inc_sat(16'(m3_s), 16'h000F));
          if (aa & bb) begin
            m1_c = inc_sat(m1_c, 16'hFFFF);
            m3_c = 4'(inc_sat(16'(m3_c), 16'h000F));
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Assert reset between edges and verify everything clears immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_p1_pipe", 32'({ov1, sq1, cq1}), 32'd0);
    chk("rst_p3_pipe", 32'({ov3, sq3, cq3}), 32'd0);
    chk("rst_cnts", 32'({sc1, cc1}), 32'd0);
    chk("rst_cnts3", 32'({sc3, cc3}), 32'd0);
    q1.delete(); q3.delete();
    m1_s = '0; m1_c = '0; m3_s = '0; m3_c = '0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  vec_t tt[4];
  logic ov1_rec[5], ov3_rec[5], sq3_rec[5], cq3_rec[5];

  initial begin
    tt[0] = '{a: 1'b0, b: 1'b0, sum: 1'b0, carry: 1'b0};
    tt[1] = '{a: 1'b0, b: 1'b1, sum: 1'b1, carry: 1'b0};
    tt[2] = '{a: 1'b1, b: 1'b0, sum: 1'b1, carry: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, sum: 1'b0, carry: 1'b1};

    rst_n = 1'b0; a = 1'b0; b = 1'b0; in_valid = 1'b0; stats_clr = 1'b0;
    m1_s = '0; m1_c = '0; m3_s = '0; m3_c = '0;

    // Truth table while reset is held; registered outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      a = tt[i].a; b = tt[i].b;
      #2;
      chk("tt_sum_rst",   32'(sum1),   32'(tt[i].sum));
      chk("tt_carry_rst", 32'(carry1), 32'(tt[i].carry));
      chk("tt_sum3_rst",  32'(sum3),   32'(tt[i].sum));
      chk("tt_rst_pipe",  32'({ov1, ov3}), 32'd0);
    end

    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming: truth table back-to-back twice, then drain.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        step(1'b1, tt[i].a, tt[i].b, 1'b0);
        chk("tt_sum", 32'(sum1), 32'(tt[i].sum));
        chk("tt_carry", 32'(carry1), 32'(tt[i].carry));
      end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(9) == 0));

    // Reset with samples in flight; no stale valid afterwards.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Latency: single 11 pulse.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ov1_rec[0] = ov1; ov3_rec[0] = ov3; sq3_rec[0] = sq3; cq3_rec[0] = cq3;
    for (int k = 1; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      ov1_rec[k] = ov1; ov3_rec[k] = ov3; sq3_rec[k] = sq3; cq3_rec[k] = cq3;
    end
    for (int k = 0; k < 5; k++) begin
      chk("lat_p1_valid", 32'(ov1_rec[k]), 32'(k == 0));
      chk("lat_p3_valid", 32'(ov3_rec[k]), 32'(k == 2));
    end
    chk("lat_p3_sum",   32'(sq3_rec[2]), 32'd0);
    chk("lat_p3_carry", 32'(cq3_rec[2]), 32'd1);

    // Counters: 20 valid samples, 6 with carry; 4-bit counter saturates.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 6) step(1'b1, 1'b1, 1'b1, 1'b0);
      else if (i % 3 == 0) step(1'b1, 1'b0, 1'b1, 1'b0);
      else if (i % 3 == 1) step(1'b1, 1'b1, 1'b0, 1'b0);
      else step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("cnt3_sat_sample", 32'(sc3), STATS ? 32'd15 : 32'd0);
    chk("cnt3_carry",      32'(cc3), STATS ? 32'd6  : 32'd0);
    chk("cnt1_sample",     32'(sc1), STATS ? 32'd20 : 32'd0);
    chk("cnt1_carry",      32'(cc1), STATS ? 32'd6  : 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_prio", 32'({sc1, cc1, sc3, cc3}), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("cnt_after_clr", 32'(sc3), STATS ? 32'd1 : 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
